// File: rtl/cache_pkg.sv
// Shared definitions for the cache block-fill logic.
//   ADDR_WIDTH      : byte-address width of the memory port
//   WORDS_PER_BLOCK : 16-bit words per cache block
//   OFFSET_BITS     : byte-offset bits inside a block
//   TAG_WIDTH       : width of the block tag
//   fill_state_e    : fill FSM state encoding
//   addr_tag()      : returns the block tag of a byte address
package cache_pkg;

  localparam int ADDR_WIDTH      = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_BITS     = 4;
  localparam int WORD_IDX_BITS   = $clog2(WORDS_PER_BLOCK);
  localparam int TAG_WIDTH       = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic logic [TAG_WIDTH-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] addr);
    return addr[ADDR_WIDTH-1:OFFSET_BITS];
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill.
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   clear    : synchronous clear (start of a new fill)
//   enable   : advance by one
//   count    : current word index
//   terminal : count is at its last value
module fill_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

  assign terminal = &count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill initiator. On a miss, issues one pipelined read per word of
// the block, streams the returned words into the data array and writes the tag
// together with the last word.
//   clk, rst_n        : clock, synchronous active-low reset
//   miss_detected     : cache miss (only looked at while idle)
//   miss_address      : byte address of the missing access
//   memory_data       : memory read data
//   memory_data_valid : memory read data valid
//   mem_enable/mem_wr : memory request strobe / write flag (always read)
//   memory_address    : memory request byte address
//   fsm_busy          : fill in progress
//   write_data_array  : write fill_data into word fill_word_sel
//   fill_word_sel     : word index being written
//   fill_data         : returned word (pass-through)
//   write_tag_array   : write fill_tag and set the valid bit
//   fill_tag          : tag of the block being filled
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_detected,
  input  logic [ADDR_WIDTH-1:0]            miss_address,
  input  logic [15:0]                      memory_data,
  input  logic                             memory_data_valid,
  output logic                             mem_enable,
  output logic                             mem_wr,
  output logic [ADDR_WIDTH-1:0]            memory_address,
  output logic                             fsm_busy,
  output logic                             write_data_array,
  output logic [WORD_IDX_BITS-1:0]         fill_word_sel,
  output logic [15:0]                      fill_data,
  output logic                             write_tag_array,
  output logic [ADDR_WIDTH-OFFSET_BITS-1:0] fill_tag
);

  localparam int TW = ADDR_WIDTH - OFFSET_BITS;

  fill_state_e             state, state_next;
  logic [TW-1:0]           base_tag;
  logic                    issue_done;
  logic                    start_fill;
  logic                    issue_en, recv_en;
  logic [WORD_IDX_BITS-1:0] issue_cnt, recv_cnt;
  logic                    issue_last, recv_last;

  // The byte offset of the miss is irrelevant: the whole block is fetched.
  logic unused_offset;
  assign unused_offset = ^miss_address[OFFSET_BITS-1:0];

  fill_counter #(.WIDTH(WORD_IDX_BITS)) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_fill),
    .enable   (issue_en),
    .count    (issue_cnt),
    .terminal (issue_last)
  );

  fill_counter #(.WIDTH(WORD_IDX_BITS)) u_recv_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_fill),
    .enable   (recv_en),
    .count    (recv_cnt),
    .terminal (recv_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      base_tag   <= '0;
      issue_done <= 1'b0;
    end else begin
      state <= state_next;
      if (start_fill) begin
        base_tag   <= miss_address[ADDR_WIDTH-1:OFFSET_BITS];
        issue_done <= 1'b0;
      end else if (issue_en && issue_last) begin
        issue_done <= 1'b1;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    start_fill       = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    mem_enable       = 1'b0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    unique case (state)
      IDLE: begin
        // Returned data seen here is stale and is dropped.
        if (miss_detected) begin
          start_fill = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_enable = 1'b1;
          issue_en   = 1'b1;
        end
        // Issue and receive are independent and may coincide.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_en          = 1'b1;
          if (recv_last) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
    endcase
  end

  // Word offset is concatenated, never added, so it cannot carry into the tag.
  assign memory_address = mem_enable ? {base_tag, issue_cnt, 1'b0} : '0;
  assign mem_wr         = 1'b0;
  assign fill_word_sel  = recv_cnt;
  assign fill_data      = memory_data;
  assign fill_tag       = base_tag;

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic [2:0]  fill_word_sel;
  logic [15:0] fill_data;
  logic        write_tag_array;
  logic [11:0] fill_tag;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .mem_enable        (mem_enable),
    .mem_wr            (mem_wr),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .fill_word_sel     (fill_word_sel),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
    .fill_tag          (fill_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Memory model: fixed-latency, in-order responses.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;
  rsp_t        rsp_q[$];
  int          latency = 4;
  logic [15:0] mem_salt = 16'h0000;

  // Reference model: a fill is "busy" until 8 words have been received;
  // 8 reads go out on the first 8 busy cycles.
  bit          model_en = 0;
  bit          m_busy;
  logic [15:0] m_base;
  int          m_issued;
  int          m_recv;

  // Per-scenario statistics, cycle numbers relative to the miss edge.
  int          cyc0, n_busy, n_req, n_wr, n_tag;
  int          first_req, last_req, first_wr, last_wr, tag_rel;
  logic [15:0] first_addr, last_addr, min_addr, first_data;
  logic [11:0] tag_val;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (16'hA000 + {1'b0, a[15:1]}) ^ mem_salt;
  endfunction

  task automatic clear_stats();
    cyc0 = cyc + 1;
    n_busy = 0; n_req = 0; n_wr = 0; n_tag = 0;
    first_req = -1; last_req = -1; first_wr = -1; last_wr = -1; tag_rel = -1;
    first_addr = 16'h0; last_addr = 16'h0; min_addr = 16'hFFFF; first_data = 16'h0;
    tag_val = 12'h0;
  endtask

  // One clock cycle: apply inputs at the falling edge, compare outputs with
  // the model, then advance memory and model as of the next rising edge.
  task automatic step(input logic rst, input logic miss, input logic [15:0] addr,
                      input logic fv);
    logic        exp_en, exp_wr, exp_tw;
    logic [15:0] exp_addr, exp_data;
    int          rel;
    @(negedge clk);
    cyc++;
    rst_n         = rst;
    miss_detected = miss;
    miss_address  = addr;
    memory_data_valid = 1'b0;
    memory_data   = 16'($urandom);
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      memory_data_valid = 1'b1;
      memory_data       = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else if (fv) begin
      memory_data_valid = 1'b1;
    end
    #1;
    exp_en   = m_busy && (m_issued < 8);
    exp_addr = m_base + 16'(2 * m_issued);
    exp_wr   = m_busy && memory_data_valid;
    exp_tw   = exp_wr && (m_recv == 7);
    exp_data = mem_word(m_base + 16'(2 * m_recv));
    if (model_en) begin
      checks++;
      if (fsm_busy !== m_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, fsm_busy, m_busy);
      end
      checks++;
      if (mem_enable !== exp_en) begin
        failures++;
        $display("FAIL mem_enable cyc=%0d got=%b exp=%b", cyc, mem_enable, exp_en);
      end
      checks++;
      if (mem_wr !== 1'b0) begin
        failures++;
        $display("FAIL mem_wr cyc=%0d got=%b exp=0", cyc, mem_wr);
      end
      if (exp_en) begin
        checks++;
        if (memory_address !== exp_addr) begin
          failures++;
          $display("FAIL address cyc=%0d got=%h exp=%h", cyc, memory_address, exp_addr);
        end
      end
      checks++;
      if (write_data_array !== exp_wr) begin
        failures++;
        $display("FAIL write_data cyc=%0d got=%b exp=%b", cyc, write_data_array, exp_wr);
      end
      checks++;
      if (write_tag_array !== exp_tw) begin
        failures++;
        $display("FAIL write_tag cyc=%0d got=%b exp=%b", cyc, write_tag_array, exp_tw);
      end
      checks++;
      if (fill_tag !== m_base[15:4]) begin
        failures++;
        $display("FAIL fill_tag cyc=%0d got=%h exp=%h", cyc, fill_tag, m_base[15:4]);
      end
      checks++;
      if (fill_data !== memory_data) begin
        failures++;
        $display("FAIL fill_data_pass cyc=%0d got=%h exp=%h", cyc, fill_data, memory_data);
      end
      if (exp_wr) begin
        checks++;
        if (fill_word_sel !== 3'(m_recv) || fill_data !== exp_data) begin
          failures++;
          $display("FAIL word cyc=%0d got sel=%0d data=%h exp sel=%0d data=%h",
                   cyc, fill_word_sel, fill_data, m_recv, exp_data);
        end
      end
    end
    rel = cyc - cyc0;
    if (rel >= 1) begin
      if (fsm_busy) n_busy++;
      if (mem_enable) begin
        if (first_req < 0) begin first_req = rel; first_addr = memory_address; end
        last_req = rel; last_addr = memory_address; n_req++;
        if (memory_address < min_addr) min_addr = memory_address;
      end
      if (write_data_array) begin
        if (first_wr < 0) begin first_wr = rel; first_data = fill_data; end
        last_wr = rel; n_wr++;
      end
      if (write_tag_array) begin tag_rel = rel; tag_val = fill_tag; n_tag++; end
    end
    // Memory side: accept the request, then reset flushes its pipeline.
    if (mem_enable) rsp_q.push_back('{due: cyc + latency, data: mem_word(memory_address)});
    if (!rst) rsp_q.delete();
    // Model update for the rising edge that ends this cycle.
    if (!rst) begin
      m_busy = 0; m_base = 16'h0; m_issued = 0; m_recv = 0;
    end else if (!m_busy) begin
      if (miss) begin
        m_busy = 1; m_base = addr & 16'hFFF0; m_issued = 0; m_recv = 0;
      end
    end else begin
      if (m_issued < 8) m_issued++;
      if (memory_data_valid) begin
        m_recv++;
        if (m_recv == 8) m_busy = 0;
      end
    end
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 16'h0, 1'b0);
    model_en = 1;
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if ({fsm_busy, mem_enable, mem_wr, write_data_array, write_tag_array} !== 5'b0 ||
        memory_address !== 16'h0 || fill_tag !== 12'h0 || fill_word_sel !== 3'h0) begin
      failures++;
      $display("FAIL reset_state got busy=%b en=%b addr=%h tag=%h sel=%0d exp all zero",
               fsm_busy, mem_enable, memory_address, fill_tag, fill_word_sel);
    end
  endtask

  task automatic test_basic_fill();
    latency = 4; mem_salt = 16'h0000;
    clear_stats();
    step(1'b1, 1'b1, 16'h1236, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (first_req != 1 || last_req != 8 || first_addr !== 16'h1230 || last_addr !== 16'h123E) begin
      failures++;
      $display("FAIL basic_issue got cyc %0d..%0d addr %h..%h exp cyc 1..8 addr 1230..123e",
               first_req, last_req, first_addr, last_addr);
    end
    checks++;
    if (first_wr != 5 || last_wr != 12 || n_wr != 8 || first_data !== 16'hA918) begin
      failures++;
      $display("FAIL basic_writes got cyc %0d..%0d n=%0d d0=%h exp cyc 5..12 n=8 d0=a918",
               first_wr, last_wr, n_wr, first_data);
    end
    checks++;
    if (tag_rel != 12 || tag_val !== 12'h123 || n_tag != 1 || n_busy != 12) begin
      failures++;
      $display("FAIL basic_tag got cyc=%0d tag=%h n=%0d busy=%0d exp cyc=12 tag=123 n=1 busy=12",
               tag_rel, tag_val, n_tag, n_busy);
    end
  endtask

  task automatic test_wrap();
    latency = 4; mem_salt = 16'h5A5A;
    clear_stats();
    step(1'b1, 1'b1, 16'hFFF8, 1'b0);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (last_addr !== 16'hFFFE || min_addr !== 16'hFFF0 || n_req != 8 || tag_val !== 12'hFFF) begin
      failures++;
      $display("FAIL wrap got last=%h min=%h n=%0d tag=%h exp last=fffe min=fff0 n=8 tag=fff",
               last_addr, min_addr, n_req, tag_val);
    end
  endtask

  task automatic test_miss_held();
    latency = 4; mem_salt = 16'h0F0F;
    clear_stats();
    step(1'b1, 1'b1, 16'h4000, 1'b0);
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 16'($urandom), 1'b0);
    checks++;
    if (n_busy != 24 || n_tag != 2 || n_req != 16 || first_addr !== 16'h4000) begin
      failures++;
      $display("FAIL miss_held got busy=%0d tags=%0d reqs=%0d a0=%h exp busy=24 tags=2 reqs=16 a0=4000",
               n_busy, n_tag, n_req, first_addr);
    end
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    latency = 4; mem_salt = 16'h1111;
    clear_stats();
    step(1'b1, 1'b1, 16'h2468, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'h0, 1'b0);
    checks++;
    if (n_tag != 0 || last_wr > 7 || n_busy != 7 || fill_tag !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid_fill got tags=%0d last_wr=%0d busy=%0d tag=%h exp tags=0 last_wr<=7 busy=7 tag=000",
               n_tag, last_wr, n_busy, fill_tag);
    end
  endtask

  task automatic test_stale_valid();
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 1'b1);
    checks++;
    if (n_wr != 0 || n_tag != 0 || n_busy != 0) begin
      failures++;
      $display("FAIL stale_valid got wr=%0d tags=%0d busy=%0d exp 0 0 0", n_wr, n_tag, n_busy);
    end
  endtask

  task automatic test_random_fills();
    logic [15:0] a;
    int          span;
    for (int f = 0; f < 20; f++) begin
      latency  = int'($urandom_range(1, 6));
      mem_salt = 16'($urandom);
      a        = 16'($urandom);
      span     = 8 + latency;
      clear_stats();
      step(1'b1, 1'b1, a, 1'b0);
      for (int i = 1; i <= span; i++) step(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);
      for (int i = 0; i < int'($urandom_range(1, 4)); i++)
        step(1'b1, 1'b0, 16'h0, 1'($urandom_range(0, 1)));
      checks++;
      if (n_wr != 8 || n_tag != 1 || n_busy != span || tag_val !== a[15:4]) begin
        failures++;
        $display("FAIL random_fill %0d lat=%0d got wr=%0d tags=%0d busy=%0d tag=%h exp 8 1 %0d %h",
                 f, latency, n_wr, n_tag, n_busy, tag_val, span, a[15:4]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data = 16'h0; memory_data_valid = 1'b0;
    clear_stats();
    test_reset();
    test_basic_fill();
    test_wrap();
    test_miss_held();
    test_reset_mid_fill();
    test_stale_valid();
    test_random_fills();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
